// File: rtl/prime_gen_pkg.sv
// ---------------------------------------------------------------------------
// prime_gen_pkg
// Shared definitions for the RSA prime-pair candidate generator.
//   state_t      : controller states (ST_PAD is only reached when the design
//                  is built with PRIME_PAIR_CONST_TIME_EN defined)
//   LFSR_TAPS    : Galois tap mask for the 8-bit candidate LFSR
//   CAND_FORCE   : OR mask that makes every candidate odd with its MSB set
//   DEFAULT_SEED : LFSR reset seed, also substituted for a zero seed
//   lfsr_next()  : one Galois LFSR step
// ---------------------------------------------------------------------------
package prime_gen_pkg;

   localparam int LFSR_W = 8;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_GEN   = 3'd1,
      ST_CHECK = 3'd2,
      ST_DONE  = 3'd3,
      ST_FAIL  = 3'd4,
      ST_PAD   = 3'd5
   } state_t;

   localparam logic [LFSR_W-1:0] LFSR_TAPS    = 8'hB8;
   localparam logic [LFSR_W-1:0] CAND_FORCE   = 8'h81;
   localparam logic [LFSR_W-1:0] DEFAULT_SEED = 8'hA5;

   // Right-shifting Galois step: the bit shifted out selects the tap mask.
   function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
      return (s >> 1) ^ (s[0] ? LFSR_TAPS : '0);
   endfunction

endpackage

// File: rtl/prime_lfsr.sv
// ---------------------------------------------------------------------------
// prime_lfsr
// 8-bit Galois LFSR that supplies raw candidate bits.
//   clk      in  : clock, rising edge
//   rst      in  : synchronous active-high reset, returns the state to SEED
//   step     in  : advance the LFSR by one step on this edge
//   load     in  : load load_val on this edge (wins over step)
//   load_val in  : seed value; zero is replaced by SEED because the all-zero
//                  state is a lock-up state of the LFSR
//   state    out : current LFSR state
// ---------------------------------------------------------------------------
module prime_lfsr
   import prime_gen_pkg::*;
#(
   parameter int                 WIDTH = LFSR_W,
   parameter logic [WIDTH-1:0]   SEED  = DEFAULT_SEED
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             step,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] state
);

   logic [WIDTH-1:0] state_reg;
   logic [WIDTH-1:0] state_next;

   always_comb begin
      state_next = state_reg;
      if (load) begin
         state_next = (load_val == '0) ? SEED : load_val;
      end else if (step) begin
         state_next = lfsr_next(state_reg);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= SEED;
      end else begin
         state_reg <= state_next;
      end
   end

   assign state = state_reg;

endmodule

// File: rtl/prime_pair_gen.sv
// ---------------------------------------------------------------------------
// prime_pair_gen
// Draws odd 8-bit candidates from an LFSR, presents them to an external
// combinational primality checker and latches the first two distinct primes
// as RSA factors p and q. Gives up after MAX_TRIES checks.
//
// Build option: PRIME_PAIR_CONST_TIME_EN
//   When defined, the search always runs the full MAX_TRIES checks; after
//   the pair is found the remaining tries go through the PAD state, which
//   advances the LFSR/candidate like GEN while the results are discarded.
//   done then appears in the same cycle fail would, hiding the search time.
//
// Ports:
//   clk       in  : clock, rising edge
//   rst       in  : synchronous active-high reset (aborts a run silently)
//   start     in  : begin a search (only honoured in IDLE)
//   seed_load in  : in IDLE, load seed into the LFSR (wins over start)
//   seed      in  : LFSR seed, zero means use SEED
//   cand      out : registered candidate, drives the checker's num input
//   is_prime  in  : checker result, combinational from cand
//   busy      out : search in progress
//   done      out : one-cycle pulse, p and q valid
//   fail      out : one-cycle pulse, tries exhausted without a pair
//   p, q      out : found primes, held until the next start or rst
//   tries     out : checks completed in the current run
// ---------------------------------------------------------------------------
module prime_pair_gen
   import prime_gen_pkg::*;
#(
   parameter int               WIDTH     = LFSR_W,
   parameter logic [WIDTH-1:0] SEED      = DEFAULT_SEED,
   parameter int               MAX_TRIES = 255
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             start,
   input  logic                             seed_load,
   input  logic [WIDTH-1:0]                 seed,
   output logic [WIDTH-1:0]                 cand,
   input  logic                             is_prime,
   output logic                             busy,
   output logic                             done,
   output logic                             fail,
   output logic [WIDTH-1:0]                 p,
   output logic [WIDTH-1:0]                 q,
   output logic [$clog2(MAX_TRIES+1)-1:0]   tries
);

   localparam int TW = $clog2(MAX_TRIES + 1);
   // One bit wider than the counter so the compare is free of overflow.
   localparam logic [TW:0] MAX_T = (TW+1)'(MAX_TRIES);

   state_t           state_reg, state_next;
   logic [WIDTH-1:0] cand_reg,  cand_next;
   logic [WIDTH-1:0] p_reg,     p_next;
   logic [WIDTH-1:0] q_reg,     q_next;
   logic [TW-1:0]    tries_reg, tries_next;
   logic             have_p_reg, have_p_next;
`ifdef PRIME_PAIR_CONST_TIME_EN
   // Pair already captured; further checks are padding only.
   logic             have_q_reg, have_q_next;
`endif

   logic [WIDTH-1:0] lfsr_state;
   logic             lfsr_step;
   logic             lfsr_load;
   logic [TW:0]      tries_inc;
   logic             last_try;
   logic             pair_found;

   prime_lfsr #(
      .WIDTH (WIDTH),
      .SEED  (SEED)
   ) u_lfsr (
      .clk      (clk),
      .rst      (rst),
      .step     (lfsr_step),
      .load     (lfsr_load),
      .load_val (seed),
      .state    (lfsr_state)
   );

   assign tries_inc = {1'b0, tries_reg} + (TW+1)'(1);
   // The check happening in this cycle is the final one allowed.
   assign last_try  = (tries_inc == MAX_T);

   always_comb begin
      state_next  = state_reg;
      cand_next   = cand_reg;
      p_next      = p_reg;
      q_next      = q_reg;
      tries_next  = tries_reg;
      have_p_next = have_p_reg;
`ifdef PRIME_PAIR_CONST_TIME_EN
      have_q_next = have_q_reg;
`endif
      lfsr_step   = 1'b0;
      lfsr_load   = 1'b0;
      pair_found  = 1'b0;

      case (state_reg)
         ST_IDLE: begin
            if (seed_load) begin
               lfsr_load = 1'b1;
            end else if (start) begin
               p_next      = '0;
               q_next      = '0;
               tries_next  = '0;
               have_p_next = 1'b0;
`ifdef PRIME_PAIR_CONST_TIME_EN
               have_q_next = 1'b0;
`endif
               state_next  = ST_GEN;
            end
         end

         ST_GEN: begin
            lfsr_step  = 1'b1;
            cand_next  = lfsr_next(lfsr_state) | CAND_FORCE;
            state_next = ST_CHECK;
         end

         ST_CHECK: begin
            tries_next = tries_inc[TW-1:0];
`ifdef PRIME_PAIR_CONST_TIME_EN
            if (have_q_reg) begin
               // Padding check: result ignored, p/q frozen.
               state_next = last_try ? ST_DONE : ST_PAD;
            end else
`endif
            begin
               if (is_prime) begin
                  if (!have_p_reg) begin
                     p_next      = cand_reg;
                     have_p_next = 1'b1;
                  end else if (cand_reg != p_reg) begin
                     q_next     = cand_reg;
                     pair_found = 1'b1;
                  end
               end

               // A pair completing on the last try beats FAIL.
               if (pair_found) begin
`ifdef PRIME_PAIR_CONST_TIME_EN
                  have_q_next = 1'b1;
                  state_next  = last_try ? ST_DONE : ST_PAD;
`else
                  state_next  = ST_DONE;
`endif
               end else if (last_try) begin
                  state_next = ST_FAIL;
               end else begin
                  state_next = ST_GEN;
               end
            end
         end

`ifdef PRIME_PAIR_CONST_TIME_EN
         ST_PAD: begin
            lfsr_step  = 1'b1;
            cand_next  = lfsr_next(lfsr_state) | CAND_FORCE;
            state_next = ST_CHECK;
         end
`endif

         ST_DONE: state_next = ST_IDLE;
         ST_FAIL: state_next = ST_IDLE;
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg  <= ST_IDLE;
         cand_reg   <= '0;
         p_reg      <= '0;
         q_reg      <= '0;
         tries_reg  <= '0;
         have_p_reg <= 1'b0;
`ifdef PRIME_PAIR_CONST_TIME_EN
         have_q_reg <= 1'b0;
`endif
      end else begin
         state_reg  <= state_next;
         cand_reg   <= cand_next;
         p_reg      <= p_next;
         q_reg      <= q_next;
         tries_reg  <= tries_next;
         have_p_reg <= have_p_next;
`ifdef PRIME_PAIR_CONST_TIME_EN
         have_q_reg <= have_q_next;
`endif
      end
   end

   // Status is decoded from the state register, so busy drops in the same
   // cycle done/fail rises and everything is low straight out of reset.
`ifdef PRIME_PAIR_CONST_TIME_EN
   assign busy = (state_reg == ST_GEN) || (state_reg == ST_CHECK) ||
                 (state_reg == ST_PAD);
`else
   assign busy = (state_reg == ST_GEN) || (state_reg == ST_CHECK);
`endif
   assign done  = (state_reg == ST_DONE);
   assign fail  = (state_reg == ST_FAIL);
   assign cand  = cand_reg;
   assign p     = p_reg;
   assign q     = q_reg;
   assign tries = tries_reg;

endmodule

// File: doc/prime_pair_gen.md
# prime_pair_gen

Sequential candidate generator and collector upstream of the combinational prime checker in the RSA key-generation path. Draws pseudo-random odd 8-bit candidates from an LFSR, drives them onto the checker's `num` input, samples its `AssumePrime` result, and latches the first two distinct primes as RSA factors `p` and `q`. Gives up after a bounded number of tries. Optionally runs in constant time to deny a timing side channel.

## Interface
- `WIDTH`, 8: candidate width. Only 8 is supported because the tap mask is fixed.
- `SEED`, 8'hA5: LFSR reset seed. Also used when a zero seed is loaded.
- `MAX_TRIES`, 255: maximum number of candidate checks per run. Must be at least 2.
- `clk` in 1: single clock. All logic is on the rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `start` in 1: begin a search. Honoured only in IDLE.
- `seed_load` in 1: in IDLE, load `seed` into the LFSR on this edge. Takes priority over `start` on the same edge.
- `seed` in WIDTH: seed value. A value of 0 is replaced by `SEED`.
- `cand` out WIDTH: registered candidate, connected to the checker's `num`.
- `is_prime` in 1: checker's `AssumePrime`, combinational from `cand`.
- `busy` out 1: high in GEN, CHECK and, under the macro, PAD.
- `done` out 1: one-cycle pulse when `p` and `q` are valid.
- `fail` out 1: one-cycle pulse when `MAX_TRIES` is exhausted without finding a pair.
- `p`, `q` out WIDTH: found primes. Held until the next `start` or `rst`.
- `tries` out $clog2(MAX_TRIES+1): number of checks completed in the current run.

## Operation
- States: IDLE, GEN, CHECK, DONE, FAIL, plus PAD when the macro is defined.
- IDLE:
  - `start` clears `p`, `q`, `tries` and the have-p flag, then moves to GEN.
  - `start` is ignored in every other state.
- GEN:
  - Advances the Galois LFSR: `s' = (s>>1) ^ (s[0] ? 8'hB8 : 0)`.
  - `cand <= s' | 8'h81`, forcing the MSB and LSB to 1.
  - Moves to CHECK.
- CHECK:
  - `cand` is held. `is_prime` is sampled at the end of the cycle and `tries` increments.
  - If prime and have-p is clear: `p <= cand` and set have-p.
  - If prime, have-p is set and `cand != p`: `q <= cand`, then go to DONE.
  - A duplicate of `p`, or a non-prime, is discarded.
  - If no pair has been found and `tries+1 == MAX_TRIES`, go to FAIL. Otherwise go to GEN.
  - A pair completing on the final try wins over FAIL.
- DONE / FAIL: assert `done` / `fail` for one cycle, then return to IDLE.
- The LFSR state persists across runs and is reset only by `rst` or `seed_load`.
- `rst` at any time, including mid-run:
  - State goes to IDLE and the LFSR to `SEED`.
  - `cand`, `p`, `q` and `tries` go to 0.
  - `busy`, `done` and `fail` go to 0.
  - No pulse is emitted for the aborted run.

## Timing
- Each try takes 2 cycles (GEN, CHECK). The checker path is combinational from the `cand` register to the `is_prime` sample.
- Latency, taking the `start` sampling edge as edge 0:
  - Earliest `done` is high in cycle 5 (GEN 1, CHECK 2, GEN 3, CHECK 4, DONE 5).
  - `fail` is high in cycle 2·MAX_TRIES+1.
- `busy` falls in the same cycle that `done` or `fail` rises.
- `p` and `q` are valid no later than the cycle in which `done` is high.

## Configuration
- `PRIME_PAIR_CONST_TIME_EN`
  - Defined:
    - After the pair is found, the block keeps cycling GEN/CHECK through the PAD path until `tries == MAX_TRIES`.
    - PAD advances the LFSR and `cand` exactly as GEN does but discards results. `p` and `q` are frozen.
    - `done` is then asserted in cycle 2·MAX_TRIES+1, identical to `fail` timing, whatever the candidate values.
  - Undefined: early exit as described above. PAD is not synthesised.

## Structure
- Package `prime_gen_pkg`: state enum, `LFSR_TAPS = 8'hB8`, `CAND_FORCE = 8'h81`, `DEFAULT_SEED = 8'hA5`.
- Sub-module `prime_lfsr`:
  - Inputs: `clk`, `rst`, `step`, `load`, `load_val`.
  - Output: `state`.
  - Applies the zero-seed substitution internally.
- The FSM, `p`/`q` capture and the tries counter live in `prime_pair_gen`.

## Test plan
- Reset behaviour: hold `rst` for 2 cycles. All outputs must be 0 and `busy` low. A `start` issued under `rst` is ignored.
- Basic pair: seed `8'hA5`, bench drives `is_prime=1` always. Required response:
  - `cand` is 0xEB, then 0xF5.
  - `p=0xEB`, `q=0xF5`, `tries=2`.
  - `done` is high in cycle 5.
- Rejection: `is_prime=0` on the first check, 1 thereafter. Required response: `p=0xF5`, `q=0x83`, `tries=3`, `done` in cycle 7.
- Failure: `MAX_TRIES=4`, `is_prime=0` always. Required response: `fail` pulses in cycle 9, `done` never asserts, `p=q=0`.
- Reset mid-run: assert `rst` during the second CHECK. Required response: no pulse, all outputs 0. A subsequent `start` must reproduce the Basic pair results exactly.
- `PRIME_PAIR_CONST_TIME_EN` with `MAX_TRIES=4` and the Basic pair stimulus:
  - `done` in cycle 9, `p=0xEB`, `q=0xF5`, `tries=4`.
  - A `start` issued in cycle 4 is ignored.
  - Loading seed 0 in IDLE must give the same sequence as `SEED`.
